// File: rtl/cascade_timer.sv
// Cascaded multi-digit up/down timer: per-digit modulo counters chained by terminal-digit enables.
// Supports parallel load with per-digit clamping, wrap or one-shot terminal behaviour.
module cascade_timer #(
  parameter int unsigned                 NUM_DIGITS = 4,
  parameter logic [4*NUM_DIGITS-1:0]     MOD_VEC    = 16'h6A6A,
  parameter logic [4*NUM_DIGITS-1:0]     INIT_VAL   = 16'h5959
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_ce,
  input  logic                    i_up_dn,
  input  logic                    i_wrap_en,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_load_val,
  input  logic                    i_stop,
  output logic [4*NUM_DIGITS-1:0] o_count,
  output logic                    o_ceo,
  output logic                    o_done
);

  logic [4*NUM_DIGITS-1:0] r_count;
  logic                    r_done;

  logic [NUM_DIGITS-1:0]   w_term;
  logic [NUM_DIGITS:0]     w_low_term;
  logic [4*NUM_DIGITS-1:0] w_next;
  logic [4*NUM_DIGITS-1:0] w_clamp;
  logic                    w_all_term;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    logic [3:0] w_dig;
    logic [3:0] w_max;
    logic [3:0] w_lv;

    assign w_dig     = r_count[4*g +: 4];
    assign w_max     = MOD_VEC[4*g +: 4] - 4'd1;
    assign w_lv      = i_load_val[4*g +: 4];
    assign w_term[g] = i_up_dn ? (w_dig == w_max) : (w_dig == 4'd0);

    // A digit steps only when every lower digit sits at its terminal value.
    assign w_next[4*g +: 4] = !w_low_term[g] ? w_dig :
                              i_up_dn ? (w_term[g] ? 4'd0  : w_dig + 4'd1) :
                                        (w_term[g] ? w_max : w_dig - 4'd1);

    assign w_clamp[4*g +: 4] = (w_lv > w_max) ? w_max : w_lv;
  end

  always_comb begin
    w_low_term[0] = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_low_term[i+1] = w_low_term[i] & w_term[i];
    end
  end

  assign w_all_term = w_low_term[NUM_DIGITS];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= INIT_VAL;
      r_done  <= 1'b0;
    end else if (i_stop) begin
      r_count <= '0;
      r_done  <= 1'b0;
    end else if (i_load) begin
      r_count <= w_clamp;
      r_done  <= 1'b0;
    end else if (i_ce && !r_done) begin
      // At terminal in one-shot mode the count holds and completion latches.
      if (w_all_term && !i_wrap_en) begin
        r_done <= 1'b1;
      end else begin
        r_count <= w_next;
      end
    end
  end

  assign o_count = r_count;
  assign o_done  = r_done;
  assign o_ceo   = i_ce & w_all_term & ~r_done;

endmodule

// File: tb/tb_cascade_timer.sv
// Directed bench for cascade_timer: vector table for single-edge behaviour plus
// hand sequences for one-shot completion, up-mode wrap and reduced-modulus clamping.
module tb_cascade_timer;

  logic        clk = 1'b0;
  logic        reset, ce, up_dn, wrap_en, load, stop;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        ceo, done;

  logic        reset3, ce3, up3, wrap3, load3, stop3;
  logic [3:0]  load_val3;
  logic [3:0]  count3;
  logic        ceo3, done3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cascade_timer #(
    .NUM_DIGITS(4),
    .MOD_VEC   (16'h6A6A),
    .INIT_VAL  (16'h5959)
  ) u_dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_ce      (ce),
    .i_up_dn   (up_dn),
    .i_wrap_en (wrap_en),
    .i_load    (load),
    .i_load_val(load_val),
    .i_stop    (stop),
    .o_count   (count),
    .o_ceo     (ceo),
    .o_done    (done)
  );

  cascade_timer #(
    .NUM_DIGITS(1),
    .MOD_VEC   (4'h3),
    .INIT_VAL  (4'h0)
  ) u_dut3 (
    .i_clk     (clk),
    .i_reset   (reset3),
    .i_ce      (ce3),
    .i_up_dn   (up3),
    .i_wrap_en (wrap3),
    .i_load    (load3),
    .i_load_val(load_val3),
    .i_stop    (stop3),
    .o_count   (count3),
    .o_ceo     (ceo3),
    .o_done    (done3)
  );

  typedef struct {
    logic        reset;
    logic        stop;
    logic        load;
    logic        ce;
    logic        up_dn;
    logic        wrap_en;
    logic [15:0] load_val;
    logic        exp_ceo;
    logic [15:0] exp_count;
    logic        exp_done;
    string       name;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic l, input logic c,
                       input logic u, input logic w, input logic [15:0] lv);
    reset = r; stop = s; load = l; ce = c; up_dn = u; wrap_en = w; load_val = lv;
  endtask

  // One ce tick; returns the ceo seen before the edge.
  task automatic tick(input logic u, input logic w, output logic ceo_seen);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b1, u, w, 16'h0);
    #1 ceo_seen = ceo;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_load(input logic u, input logic w, input logic [15:0] lv);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b0, u, w, lv);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic c_seen;

    //                 rst   stop  load  ce    up    wrap  load_val  ceo   count     done
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h5959, 1'b0, "reset"};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h5958, 1'b0, "down1"};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h5957, 1'b0, "down2"};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h5956, 1'b0, "down3"};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b0, 16'h1234, 1'b0, "load_over_ce"};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFF9C, 1'b0, 16'h5959, 1'b0, "load_clamp"};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b0, 16'h0000, 1'b0, "stop_prio"};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h5959, 1'b0, "reset_prio"};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 1'b0, 16'h0010, 1'b0, "load_0010"};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0009, 1'b0, "flip_down"};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0010, 1'b0, "flip_up1"};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0011, 1'b0, "flip_up2"};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, "load_zero"};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h5959, 1'b0, "down_wrap"};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h5959, 1'b0, "ce_low_hold"};

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    reset3 = 1'b1; ce3 = 1'b0; up3 = 1'b0; wrap3 = 1'b0;
    load3 = 1'b0; stop3 = 1'b0; load_val3 = 4'h0;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vecs[i].reset, vecs[i].stop, vecs[i].load, vecs[i].ce,
            vecs[i].up_dn, vecs[i].wrap_en, vecs[i].load_val);
      #1;
      if (i > 0) check({vecs[i].name, "_ceo"}, {15'h0, ceo}, {15'h0, vecs[i].exp_ceo});
      @(posedge clk);
      #1;
      check({vecs[i].name, "_count"}, count, vecs[i].exp_count);
      check({vecs[i].name, "_done"}, {15'h0, done}, {15'h0, vecs[i].exp_done});
    end

    // One-shot countdown from 01:00.
    apply_load(1'b0, 1'b0, 16'h0100);
    check("oneshot_load", count, 16'h0100);
    for (int t = 1; t <= 60; t++) begin
      tick(1'b0, 1'b0, c_seen);
      if (t == 1) check("oneshot_t1", count, 16'h0059);
      if (t == 2) check("oneshot_t2", count, 16'h0058);
      if (c_seen) check("oneshot_early_ceo", {15'h0, c_seen}, 16'h0);
    end
    check("oneshot_t60_count", count, 16'h0000);
    check("oneshot_t60_done", {15'h0, done}, 16'h0);
    @(negedge clk);
    ce = 1'b0;
    #1 check("oneshot_t60_ceo_idle", {15'h0, ceo}, 16'h0);
    tick(1'b0, 1'b0, c_seen);
    check("oneshot_t61_ceo", {15'h0, c_seen}, 16'h1);
    check("oneshot_t61_count", count, 16'h0000);
    check("oneshot_t61_done", {15'h0, done}, 16'h1);
    tick(1'b1, 1'b1, c_seen);
    check("oneshot_frozen_ceo", {15'h0, c_seen}, 16'h0);
    check("oneshot_frozen_count", count, 16'h0000);
    check("oneshot_frozen_done", {15'h0, done}, 16'h1);

    // Load clears done; up-mode wrap through 59:59.
    apply_load(1'b1, 1'b1, 16'h5958);
    check("upwrap_load_count", count, 16'h5958);
    check("upwrap_load_done", {15'h0, done}, 16'h0);
    tick(1'b1, 1'b1, c_seen);
    check("upwrap_t1_ceo", {15'h0, c_seen}, 16'h0);
    check("upwrap_t1_count", count, 16'h5959);
    tick(1'b1, 1'b1, c_seen);
    check("upwrap_t2_ceo", {15'h0, c_seen}, 16'h1);
    check("upwrap_t2_count", count, 16'h0000);
    check("upwrap_t2_done", {15'h0, done}, 16'h0);

    // Single-digit modulus-3 instance.
    @(negedge clk);
    reset3 = 1'b0; load3 = 1'b1; load_val3 = 4'h7;
    @(posedge clk);
    #1 check("mod3_clamp", {12'h0, count3}, 16'h0002);
    @(negedge clk);
    load3 = 1'b0; ce3 = 1'b1; up3 = 1'b1; wrap3 = 1'b1;
    #1 check("mod3_ceo", {15'h0, ceo3}, 16'h1);
    @(posedge clk);
    #1 check("mod3_wrap", {12'h0, count3}, 16'h0000);
    @(negedge clk);
    ce3 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
